reg_display_scan: RTL and testbench
===================================

// Module: reg_display_scan
// PURPOSE
//  Downstream of alphacore. Captures the 32-bit register value on reg_read_data_1 (the register picked by
//  switch_select) and shows it as 8 hex digits on a time-multiplexed common-anode 7-segment display.
//  Provides a digit scan counter with dead time, leading-zero blanking and tear-free update at digit-slot boundaries.
// PARAMETERS
//  REFRESH_DIV  16  fastclk cycles per digit slot; must be >= 2 (elaboration error otherwise)
//  BLANK_LZ     1   1 = blank leading zero digits (digit 0 never blanked); 0 = show all 8 digits
// PORTS
//  fastclk          in   1   system clock, rising edge
//  reset            in   1   asynchronous, active-high reset
//  reg_read_data_1  in   32  register value from alphacore
//  load             in   1   1-cycle strobe: sample reg_read_data_1 and dp_mask into shadow
//  dp_mask          in   8   per-digit decimal point enable (bit i -> digit i)
//  an_n             out  8   digit anodes, active-low; bit 0 = least-significant nibble
//  seg_n            out  7   segments {g,f,e,d,c,b,a}, active-low
//  dp_n             out  1   decimal point, active-low
// BEHAVIOUR
//  - Reset (async): shadow=0, disp=0, masks=0, cnt=0, idx=0; an_n=8'hFF, seg_n=7'h7F, dp_n=1. Held while reset=1.
//  - cnt counts 0..REFRESH_DIV-1 and wraps. At cnt==REFRESH_DIV-1 (slot boundary): idx<=idx+1 mod 8,
//    disp<=shadow, disp_dp<=shadow_dp.
//  - All outputs come straight from flops. The next-state value is computed from the post-edge cnt/idx:
//    cnt==0 -> dead cycle: an_n=FF, seg_n=7F, dp_n=1.
//    cnt>=1 -> an_n=~(1<<idx); seg_n=hex7seg(disp[4*idx+:4]) or 7F if blanked; dp_n=~disp_dp[idx].
//  - First non-dead an_n (8'hFE) appears 2 edges after reset release; full scan period = 8*REFRESH_DIV cycles.
//  - load: shadow<=reg_read_data_1, shadow_dp<=dp_mask on the same edge. The new value becomes visible at the
//    next slot boundary. If load coincides with a boundary, that boundary copies the OLD shadow, so the new value
//    appears one slot later. Back-to-back loads: last one wins. No tearing: disp is constant within a slot.
//  - Blanking (BLANK_LZ=1): digit i (i>=1) is blanked iff disp[31:4*i]==0. disp==0 shows only "0" on digit 0.
//    A blanked digit still gets its anode strobe. Its seg_n is 7F; dp_n still follows disp_dp.
//  - Reset mid-slot: outputs drop to reset values immediately (async). The scan restarts at idx 0, cnt 0.
// STRUCTURE
//  - Shared package alpha_disp_pkg: SEG_OFF=7'h7F, AN_OFF=8'hFF, NUM_DIGITS=8, 16-entry active-low hex table:
//    0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
//  - Sub-module hex_to_7seg (combinational nibble -> seg_n, uses the package table). Top holds the
//    counters, shadow/disp registers, blanking logic and output flops.
// TESTING (bench uses REFRESH_DIV=4; period 32 cycles)
//  1. Release reset, no load -> an_n: FF,FF(dead),FE,FE,FE,FF,FD,... seg_n on digit0 = 7'h40, all others 7F.
//  2. load 32'h12345678, BLANK_LZ=0 -> after the next boundary: digit0 seg_n=7'h00 ("8"), digit3 7'h12 ("5"),
//     digit7 7'h79 ("1"). No digit changes value mid-slot.
//  3. load 32'h000000A0 -> digit0 7'h40, digit1 7'h08, digits2..7 7'h7F. Anodes still strobe.
//  4. load on the boundary cycle -> the following slot still shows the old value. The new value shows from the
//     slot after. Two loads 1 cycle apart -> only the second value is displayed.
//  5. dp_mask=8'h81 with the load -> dp_n=0 only while an_n=FE or 7F (non-dead cycles). 1 elsewhere.
//  6. Assert reset at cnt=2 of digit 5 -> the same timestep gives an_n=FF, seg_n=7F, dp_n=1. After release,
//     the scan restarts at digit 0 and the display shows 0.

Source files
------------

// File: rtl/alpha_disp_pkg.sv
// Shared constants for the alphacore 7-segment register display.
// Encodings are active-low {g,f,e,d,c,b,a}.
package alpha_disp_pkg;

    localparam logic [6:0]  SEG_OFF    = 7'h7F;
    localparam logic [7:0]  AN_OFF     = 8'hFF;
    localparam int unsigned NUM_DIGITS = 8;

    // Entry 15 first: F E d C b A 9 8 7 6 5 4 3 2 1 0
    localparam logic [15:0][6:0] HEX7SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble to active-low 7-segment pattern.
module hex_to_7seg
    import alpha_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = HEX7SEG_TABLE[nibble];
    end

endmodule

// File: rtl/reg_display_scan.sv
// Time-multiplexed 8-digit hex display of a captured register value, with a dead
// cycle per digit slot, optional leading-zero blanking and slot-aligned updates.
module reg_display_scan
    import alpha_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 16,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic        fastclk,
    input  logic        reset,
    input  logic [31:0] reg_read_data_1,
    input  logic        load,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n
);

    localparam int unsigned      CNT_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    if (REFRESH_DIV < 2) begin : g_div_check
        $error("reg_display_scan: REFRESH_DIV must be >= 2");
    end

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            idx_q, idx_d;
    logic [31:0]           shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
    logic [31:0]           disp_q, disp_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic [7:0]            an_n_q, an_n_d;
    logic [6:0]            seg_n_q, seg_n_d;
    logic                  dp_n_q, dp_n_d;

    logic        slot_end;
    logic [31:0] upper;
    logic [3:0]  nibble;
    logic        blank;
    logic [6:0]  hex_seg;

    hex_to_7seg u_hex (
        .nibble (nibble),
        .seg_n  (hex_seg)
    );

    // Current digit sits in the low nibble of upper; blank when nothing above it is set.
    always_comb begin
        upper  = disp_q >> {idx_q, 2'b00};
        nibble = upper[3:0];
        blank  = BLANK_LZ && (idx_q != 3'd0) && (upper == '0);
    end

    always_comb begin
        slot_end    = (cnt_q == CNT_LAST);
        cnt_d       = slot_end ? '0 : cnt_q + 1'b1;
        idx_d       = slot_end ? idx_q + 3'd1 : idx_q;
        shadow_d    = load ? reg_read_data_1 : shadow_q;
        shadow_dp_d = load ? dp_mask : shadow_dp_q;
        disp_d      = slot_end ? shadow_q : disp_q;
        disp_dp_d   = slot_end ? shadow_dp_q : disp_dp_q;

        an_n_d  = AN_OFF;
        seg_n_d = SEG_OFF;
        dp_n_d  = 1'b1;
        if (cnt_q != '0) begin
            an_n_d  = ~(8'b1 << idx_q);
            seg_n_d = blank ? SEG_OFF : hex_seg;
            dp_n_d  = ~disp_dp_q[idx_q];
        end
    end

    always_ff @(posedge fastclk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            disp_q      <= '0;
            disp_dp_q   <= '0;
            an_n_q      <= AN_OFF;
            seg_n_q     <= SEG_OFF;
            dp_n_q      <= 1'b1;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            disp_q      <= disp_d;
            disp_dp_q   <= disp_dp_d;
            an_n_q      <= an_n_d;
            seg_n_q     <= seg_n_d;
            dp_n_q      <= dp_n_d;
        end
    end

    always_comb begin
        an_n  = an_n_q;
        seg_n = seg_n_q;
        dp_n  = dp_n_q;
    end

endmodule

// File: tb/tb_reg_display_scan.sv
// Directed bench for reg_display_scan with REFRESH_DIV=4, one blanking and one
// non-blanking instance driven in lockstep.
module tb_reg_display_scan;

    logic        fastclk;
    logic        reset;
    logic [31:0] reg_read_data_1;
    logic        load;
    logic [7:0]  dp_mask;
    logic [7:0]  an_n, an_n_nb;
    logic [6:0]  seg_n, seg_n_nb;
    logic        dp_n, dp_n_nb;

    int tests_run;
    int tests_failed;
    int e;

    logic [7:0] t1_an [10] = '{8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFF,
                               8'hFD, 8'hFD, 8'hFD, 8'hFF, 8'hFB};

    reg_display_scan #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) u_dut (
        .fastclk         (fastclk),
        .reset           (reset),
        .reg_read_data_1 (reg_read_data_1),
        .load            (load),
        .dp_mask         (dp_mask),
        .an_n            (an_n),
        .seg_n           (seg_n),
        .dp_n            (dp_n)
    );

    reg_display_scan #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) u_dut_nb (
        .fastclk         (fastclk),
        .reset           (reset),
        .reg_read_data_1 (reg_read_data_1),
        .load            (load),
        .dp_mask         (dp_mask),
        .an_n            (an_n_nb),
        .seg_n           (seg_n_nb),
        .dp_n            (dp_n_nb)
    );

    initial fastclk = 1'b0;
    always #5 fastclk = ~fastclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, e);
        end
    endtask

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [3:0] nib(input logic [31:0] v, input int d);
        logic [31:0] t;
        t = v >> (4 * d);
        return t[3:0];
    endfunction

    // e counts rising edges since the last reset release; all driving/sampling at negedge.
    task automatic step(input int n);
        repeat (n) @(negedge fastclk);
        e += n;
    endtask

    // Advance to the sample showing cnt==1 of digit d.
    task automatic seek(input int d);
        step(1);
        while (((e - 2) % 32) != 4 * d) step(1);
    endtask

    task automatic do_load(input logic [31:0] v, input logic [7:0] m, output int l_edge);
        reg_read_data_1 = v;
        dp_mask         = m;
        load            = 1'b1;
        step(1);
        load            = 1'b0;
        l_edge          = e;
    endtask

    // A load at edge L reaches disp at the first multiple of 4 strictly after L.
    task automatic wait_visible(input int l_edge);
        int b;
        b = (l_edge / 4 + 1) * 4;
        while (e < b + 1) step(1);
    endtask

    task automatic scan_period(input logic [31:0] v, input logic [7:0] m);
        int s, c, d;
        for (int i = 0; i < 32; i++) begin
            step(1);
            s = e - 1;
            c = s % 4;
            d = (s / 4) % 8;
            if (c == 0) begin
                chk("scan_an_dead", {24'h0, an_n}, 32'hFF);
                chk("scan_seg_dead", {25'h0, seg_n}, 32'h7F);
                chk("scan_dp_dead", {31'h0, dp_n}, 32'h1);
            end else begin
                chk("scan_an", {24'h0, an_n}, {24'h0, ~(8'b1 << d)});
                chk("scan_seg", {25'h0, seg_n}, {25'h0, hex7(nib(v, d))});
                chk("scan_dp", {31'h0, dp_n}, {31'h0, ~m[d]});
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int l_edge, d;
        tests_run       = 0;
        tests_failed    = 0;
        e               = 0;
        reset           = 1'b1;
        load            = 1'b0;
        reg_read_data_1 = '0;
        dp_mask         = '0;

        repeat (3) @(negedge fastclk);
        chk("rst_an", {24'h0, an_n}, 32'hFF);
        chk("rst_seg", {25'h0, seg_n}, 32'h7F);
        chk("rst_dp", {31'h0, dp_n}, 32'h1);
        chk("rst_an_nb", {24'h0, an_n_nb}, 32'hFF);

        // Scan start-up with nothing loaded.
        reset = 1'b0;
        e     = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("t1_an", {24'h0, an_n}, {24'h0, t1_an[i]});
            if (i == 1) begin
                chk("t1_seg_d0", {25'h0, seg_n}, 32'h40);
                chk("t1_dp_d0", {31'h0, dp_n}, 32'h1);
            end
            if (i == 5) begin
                chk("t1_seg_d1_blank", {25'h0, seg_n}, 32'h7F);
                chk("t1_seg_d1_nb", {25'h0, seg_n_nb}, 32'h40);
            end
        end

        do_load(32'h12345678, 8'h00, l_edge);
        wait_visible(l_edge);
        seek(0);
        chk("t2_seg_d0", {25'h0, seg_n_nb}, 32'h00);
        seek(3);
        chk("t2_seg_d3", {25'h0, seg_n_nb}, 32'h12);
        seek(7);
        chk("t2_seg_d7", {25'h0, seg_n_nb}, 32'h79);
        chk("t2_seg_d7_blz", {25'h0, seg_n}, 32'h79);

        // Mid-slot load must not change the digit for the rest of the slot.
        seek(3);
        do_load(32'h000000A0, 8'h00, l_edge);
        chk("t2_tear_c2", {25'h0, seg_n}, 32'h12);
        step(1);
        chk("t2_tear_c3", {25'h0, seg_n}, 32'h12);

        wait_visible(l_edge);
        seek(0);
        chk("t3_seg_d0", {25'h0, seg_n}, 32'h40);
        seek(1);
        chk("t3_seg_d1", {25'h0, seg_n}, 32'h08);
        chk("t3_seg_d1_nb", {25'h0, seg_n_nb}, 32'h08);
        seek(2);
        chk("t3_an_d2", {24'h0, an_n}, 32'hFB);
        chk("t3_seg_d2_blank", {25'h0, seg_n}, 32'h7F);
        chk("t3_seg_d2_nb", {25'h0, seg_n_nb}, 32'h40);
        seek(7);
        chk("t3_an_d7", {24'h0, an_n}, 32'h7F);
        chk("t3_seg_d7_blank", {25'h0, seg_n}, 32'h7F);
        chk("t3_seg_d7_nb", {25'h0, seg_n_nb}, 32'h40);

        // Load landing exactly on a slot boundary edge.
        while (((e + 1) % 4) != 0) step(1);
        do_load(32'h12345678, 8'h00, l_edge);
        d = (l_edge / 4) % 8;
        step(1);
        chk("t4_bnd_dead", {24'h0, an_n}, 32'hFF);
        step(1);
        chk("t4_bnd_old", {25'h0, seg_n_nb}, {25'h0, hex7(nib(32'h000000A0, d))});
        step(4);
        chk("t4_bnd_new", {25'h0, seg_n_nb}, {25'h0, hex7(nib(32'h12345678, (d + 1) % 8))});

        seek(0);
        do_load(32'h11111111, 8'h00, l_edge);
        do_load(32'h22222222, 8'h00, l_edge);
        wait_visible(l_edge);
        scan_period(32'h22222222, 8'h00);

        do_load(32'h12345678, 8'h81, l_edge);
        wait_visible(l_edge);
        scan_period(32'h12345678, 8'h81);

        // Asynchronous reset in the middle of digit 5's slot.
        seek(5);
        step(1);
        chk("t6_pre_an", {24'h0, an_n}, 32'hDF);
        chk("t6_pre_seg", {25'h0, seg_n}, 32'h30);
        reset = 1'b1;
        #1;
        chk("t6_rst_an", {24'h0, an_n}, 32'hFF);
        chk("t6_rst_seg", {25'h0, seg_n}, 32'h7F);
        chk("t6_rst_dp", {31'h0, dp_n}, 32'h1);
        step(2);
        reset = 1'b0;
        e     = 0;
        step(1);
        chk("t6_post_dead", {24'h0, an_n}, 32'hFF);
        step(1);
        chk("t6_post_an", {24'h0, an_n}, 32'hFE);
        chk("t6_post_seg", {25'h0, seg_n}, 32'h40);
        chk("t6_post_dp", {31'h0, dp_n}, 32'h1);
        chk("t6_post_seg_nb", {25'h0, seg_n_nb}, 32'h40);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
